// File: rtl/dcache_pkg.sv
// Shared types and geometry for the dcache miss controller.
// Geometry: 64 lines, direct-mapped, 256-bit lines, 32-bit words.
package dcache_pkg;
    localparam int ADDR_W    = 32;
    localparam int LINE_W    = 256;
    localparam int INDEX_W   = 6;
    localparam int OFFSET_W  = 5;
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int TAG_LSB   = OFFSET_W + INDEX_W;
    localparam int INDEX_LSB = OFFSET_W;
    localparam int WSEL_LSB  = 2;
    localparam int WSEL_W    = OFFSET_W - WSEL_LSB;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

    typedef enum logic [2:0] {
        INIT, IDLE, COMPARE, WRITE, WRITEBACK, ALLOCATE, FILL, DONE
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } cpu_req_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/dcache_stats.sv
// Saturating hit / miss / writeback event counters for dcache_ctrl.
// Only instantiated when DCACHE_STATS_EN is defined.
module dcache_stats
    import dcache_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hit_inc,
    input  logic        miss_inc,
    input  logic        wb_inc,
    output logic [31:0] hits,
    output logic [31:0] misses,
    output logic [31:0] wbs
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits   <= '0;
            misses <= '0;
            wbs    <= '0;
        end else begin
            if (hit_inc)  hits   <= sat_inc(hits);
            if (miss_inc) misses <= sat_inc(misses);
            if (wb_inc)   wbs    <= sat_inc(wbs);
        end
    end
endmodule

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM in front of the direct-mapped dcache data/tag array.
// Define DCACHE_STATS_EN to add saturating hit/miss/writeback counters.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              c_enable,
    output logic              c_rst,
    output logic              c_compare,
    output logic              c_read,
    output logic [ADDR_W-1:0] c_address,
    output logic [31:0]       c_data_in,
    output logic [3:0]        c_byte_w_en,
    output logic [LINE_W-1:0] c_data_line_in,
    input  logic              c_hit,
    input  logic              c_valid,
    input  logic              c_dirty,
    input  logic [31:0]       c_data_out,
    input  logic [LINE_W-1:0] c_data_line_out,
    input  logic [ADDR_W-1:0] c_address_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_wbs
`endif
);
    state_t            state;
    cpu_req_t          req;
    logic [LINE_W-1:0] victim_line;
    logic [LINE_W-1:0] refill_line;
    logic              real_hit;

    // c_hit is only a tag match; an invalid line with a stale tag must miss.
    assign real_hit       = c_hit & c_valid;
    assign c_address      = req.addr;
    assign c_data_in      = req.wdata;
    assign c_data_line_in = refill_line;
    assign mem_wdata      = victim_line;

    // All strobes are registered: each branch sets what the next state drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            req         <= '0;
            victim_line <= '0;
            refill_line <= '0;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            c_enable    <= 1'b0;
            c_rst       <= 1'b0;
            c_compare   <= 1'b0;
            c_read      <= 1'b0;
            c_byte_w_en <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
        end else begin
            cpu_ready   <= 1'b0;
            c_enable    <= 1'b0;
            c_rst       <= 1'b0;
            c_compare   <= 1'b0;
            c_read      <= 1'b0;
            c_byte_w_en <= '0;
            case (state)
                INIT: begin
                    // First cycle raises the invalidate strobe, second leaves.
                    if (!c_rst) begin
                        c_enable <= 1'b1;
                        c_rst    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (cpu_req) begin
                        req       <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, be: cpu_be};
                        state     <= COMPARE;
                        c_enable  <= 1'b1;
                        c_compare <= 1'b1;
                        c_read    <= 1'b1;
                    end
                end
                COMPARE: begin
                    if (real_hit) begin
                        if (req.we) begin
                            state       <= WRITE;
                            c_enable    <= 1'b1;
                            c_compare   <= 1'b1;
                            c_byte_w_en <= req.be;
                        end else begin
                            cpu_rdata <= c_data_out;
                            cpu_ready <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        victim_line <= c_data_line_out;
                        mem_req     <= 1'b1;
                        if (c_valid && c_dirty) begin
                            state    <= WRITEBACK;
                            mem_we   <= 1'b1;
                            mem_addr <= c_address_out & LINE_MASK;
                        end else begin
                            state    <= ALLOCATE;
                            mem_we   <= 1'b0;
                            mem_addr <= req.addr & LINE_MASK;
                        end
                    end
                end
                WRITE: begin
                    cpu_ready <= 1'b1;
                    state     <= DONE;
                end
                WRITEBACK: begin
                    // mem_req stays high straight into the refill read.
                    if (mem_ack) begin
                        state    <= ALLOCATE;
                        mem_we   <= 1'b0;
                        mem_addr <= req.addr & LINE_MASK;
                    end
                end
                ALLOCATE: begin
                    if (mem_ack) begin
                        refill_line <= mem_rdata;
                        mem_req     <= 1'b0;
                        mem_addr    <= '0;
                        state       <= FILL;
                        c_enable    <= 1'b1;
                    end
                end
                FILL: begin
                    state     <= COMPARE;
                    c_enable  <= 1'b1;
                    c_compare <= 1'b1;
                    c_read    <= 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic retry;
    logic first_cmp;

    // Compares reached from FILL are retries and are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               retry <= 1'b0;
        else if (state == IDLE)   retry <= 1'b0;
        else if (state == FILL)   retry <= 1'b1;
    end

    assign first_cmp = (state == COMPARE) && !retry;

    dcache_stats u_stats (
        .clk      (clk),
        .rst_n    (rst_n),
        .hit_inc  (first_cmp & real_hit),
        .miss_inc (first_cmp & ~real_hit),
        .wb_inc   ((state == WRITEBACK) & mem_ack),
        .hits     (stat_hits),
        .misses   (stat_misses),
        .wbs      (stat_wbs)
    );
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural array + memory around the DUT, checked
// against a transaction-level model of what memory and the CPU should see.
module tb_dcache_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]   cpu_be = '0;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         c_enable, c_rst, c_compare, c_read;
    logic [31:0]  c_address, c_data_in;
    logic [3:0]   c_byte_w_en;
    logic [255:0] c_data_line_in;
    logic         c_hit = 1'b0, c_valid = 1'b0, c_dirty = 1'b0;
    logic [31:0]  c_data_out = '0, c_address_out = '0;
    logic [255:0] c_data_line_out = '0;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_ack = 1'b0;
    logic [255:0] mem_rdata = '0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  stat_hits, stat_misses, stat_wbs;
    int           m_hits = 0, m_misses = 0, m_wbs = 0;
`endif

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .c_enable(c_enable), .c_rst(c_rst), .c_compare(c_compare), .c_read(c_read),
        .c_address(c_address), .c_data_in(c_data_in), .c_byte_w_en(c_byte_w_en),
        .c_data_line_in(c_data_line_in), .c_hit(c_hit), .c_valid(c_valid), .c_dirty(c_dirty),
        .c_data_out(c_data_out), .c_data_line_out(c_data_line_out), .c_address_out(c_address_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs)
`endif
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural data/tag array, updating on negedge like the real one.
    logic [20:0]  a_tag  [64];
    logic         a_val  [64];
    logic         a_dirty[64];
    logic [255:0] a_line [64];

    always @(negedge clk) begin
        int i, w;
        i = int'(c_address[10:5]);
        w = int'(c_address[4:2]);
        if (c_enable && c_rst) begin
            for (int k = 0; k < 64; k++) begin a_val[k] = 1'b0; a_dirty[k] = 1'b0; end
        end else if (c_enable && c_compare && c_read) begin
            c_hit           = (a_tag[i] == c_address[31:11]);
            c_valid         = a_val[i];
            c_dirty         = a_dirty[i];
            c_data_out      = a_line[i][32*w +: 32];
            c_data_line_out = a_line[i];
            c_address_out   = {a_tag[i], 6'(i), 5'b0};
        end else if (c_enable && c_compare) begin
            if (a_val[i] && a_tag[i] == c_address[31:11]) begin
                for (int b = 0; b < 4; b++)
                    if (c_byte_w_en[b]) a_line[i][32*w + 8*b +: 8] = c_data_in[8*b +: 8];
                a_dirty[i] = 1'b1;
            end
        end else if (c_enable) begin
            a_line[i]  = c_data_line_in;
            a_tag[i]   = c_address[31:11];
            a_val[i]   = 1'b1;
            a_dirty[i] = 1'b0;
        end
    end

    // Memory responder: acks after a programmable number of request cycles.
    logic [255:0] mem_img [logic [31:0]];
    int           wb_delay = 0, rf_delay = 0, rsp_cnt = 0, wb_cycles = 0, rf_cycles = 0;
    logic         exp_wb, exp_rf;
    logic [31:0]  exp_wb_addr, exp_rf_addr, exp_rdata, seen_wb_addr, seen_rf_addr;
    logic [255:0] exp_wb_data, seen_wb_data;
    int           exp_lat;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack = 1'b0;
            rsp_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            rsp_cnt = 0;
        end else if (mem_req) begin
            if (mem_we) begin
                wb_cycles++;
                check("wb_addr", mem_addr, exp_wb_addr);
                check("wb_data", mem_wdata, exp_wb_data);
                if (rsp_cnt == wb_delay) begin
                    mem_ack = 1'b1; seen_wb_addr = mem_addr; seen_wb_data = mem_wdata;
                end else rsp_cnt++;
            end else begin
                rf_cycles++;
                check("rf_addr", mem_addr, exp_rf_addr);
                if (rsp_cnt == rf_delay) begin
                    mem_ack = 1'b1; seen_rf_addr = mem_addr;
                    mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : '0;
                end else rsp_cnt++;
            end
        end
    end

    // Reference: golden per-line data, plus which tag each set holds and whether dirty.
    logic [255:0] gold [logic [31:0]];
    logic [20:0]  r_tag  [64];
    bit           r_val  [64];
    bit           r_dirty[64];

    task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int wbd, input int rfd);
        logic [31:0] la, vla;
        logic [255:0] ln;
        int idx, w;
        bit hit;
        la  = {addr[31:5], 5'b0};
        idx = int'(addr[10:5]);
        w   = int'(addr[4:2]);
        if (!gold.exists(la)) begin
            for (int k = 0; k < 8; k++) ln[32*k +: 32] = $urandom;
            gold[la] = ln; mem_img[la] = ln;
        end
        hit         = r_val[idx] && r_tag[idx] == addr[31:11];
        exp_wb      = !hit && r_val[idx] && r_dirty[idx];
        exp_rf      = !hit;
        exp_rf_addr = la;
        if (exp_wb) begin
            vla = {r_tag[idx], 6'(idx), 5'b0};
            exp_wb_addr = vla; exp_wb_data = gold[vla]; mem_img[vla] = gold[vla];
        end
        if (!hit) begin r_val[idx] = 1'b1; r_tag[idx] = addr[31:11]; r_dirty[idx] = 1'b0; end
        ln = gold[la];
        if (we) begin
            for (int b = 0; b < 4; b++) if (be[b]) ln[32*w + 8*b +: 8] = wdata[8*b +: 8];
            gold[la] = ln; r_dirty[idx] = 1'b1;
        end
        exp_rdata = ln[32*w +: 32];
        exp_lat = (we ? 3 : 2) + (hit ? 0 : (rfd + 1) + 2 + (exp_wb ? wbd + 2 : 0));
`ifdef DCACHE_STATS_EN
        if (hit) m_hits++; else m_misses++;
        if (exp_wb) m_wbs++;
`endif
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int wbd, input int rfd, input bit noise,
                          output logic [31:0] rd);
        int n;
        predict(we, addr, wdata, be, wbd, rfd);
        wb_delay = wbd; rf_delay = rfd; wb_cycles = 0; rf_cycles = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (cpu_ready) break;
            cpu_req = noise && (n == 3);
            cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom; cpu_be = 4'($urandom);
        end
        cpu_req = 1'b0;
        rd = cpu_rdata;
        if (!cpu_ready) begin
            check("ready_timeout", cpu_ready, 1'b1);
            return;
        end
        check("latency", n, exp_lat);
        if (!we) check("rdata", cpu_rdata, exp_rdata);
        check("wb_cycles", wb_cycles, exp_wb ? wbd + 1 : 0);
        check("rf_cycles", rf_cycles, exp_rf ? rfd + 1 : 0);
        @(negedge clk);
        check("ready_pulse", cpu_ready, 1'b0);
    endtask

    task automatic release_reset();
        int cnt;
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (c_rst) begin cnt++; check("c_rst_enable", c_enable, 1'b1); end
        end
        check("c_rst_cycles", cnt, 1);
        // Dirty data held only in the cache is lost by the invalidate.
        for (int i = 0; i < 64; i++) begin
            if (r_val[i] && r_dirty[i]) gold[{r_tag[i], 6'(i), 5'b0}] = mem_img[{r_tag[i], 6'(i), 5'b0}];
            r_val[i] = 1'b0; r_dirty[i] = 1'b0;
        end
`ifdef DCACHE_STATS_EN
        m_hits = 0; m_misses = 0; m_wbs = 0;
`endif
    endtask

    initial begin
        logic [31:0]  rd;
        logic [255:0] ln;
        logic [20:0]  tags [4];
        logic [5:0]   idxs [4];
        tags = '{21'h2, 21'h3, 21'h1ABCD, 21'h0};
        idxs = '{6'd2, 6'd5, 6'd63, 6'd0};
        for (int i = 0; i < 64; i++) begin
            a_tag[i] = '0; a_val[i] = 1'b0; a_dirty[i] = 1'b0; a_line[i] = '0;
            r_tag[i] = '0; r_val[i] = 1'b0; r_dirty[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", cpu_ready, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_c_enable", c_enable, 1'b0);
        check("rst_c_rst", c_rst, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        release_reset();

        // Cold load miss, no writeback.
        for (int k = 0; k < 8; k++) ln[32*k +: 32] = $urandom;
        ln[64 +: 32] = 32'hDEADBEEF;
        gold[32'h1040] = ln; mem_img[32'h1040] = ln;
        do_req(1'b0, 32'h0000_1048, 32'h0, 4'h0, 0, 0, 1'b0, rd);
        check("t1_rdata", rd, 32'hDEADBEEF);
        check("t1_rf_addr", seen_rf_addr, 32'h0000_1040);

        // Load hit.
        do_req(1'b0, 32'h0000_1048, 32'h0, 4'h0, 0, 0, 1'b0, rd);
        check("t2_rdata", rd, 32'hDEADBEEF);

        // Partial store hit then readback.
        do_req(1'b1, 32'h0000_1048, 32'h1122_3344, 4'b0011, 0, 0, 1'b0, rd);
        do_req(1'b0, 32'h0000_1048, 32'h0, 4'h0, 0, 0, 1'b0, rd);
        check("t3_rdata", rd, 32'hDEAD3344);

        // Conflict miss evicts the dirty line.
        do_req(1'b0, 32'h0000_1848, 32'h0, 4'h0, 2, 1, 1'b0, rd);
        check("t4_wb_addr", seen_wb_addr, 32'h0000_1040);
        check("t4_wb_word2", seen_wb_data[64 +: 32], 32'hDEAD3344);
        check("t4_rf_addr", seen_rf_addr, 32'h0000_1840);

        // Slow memory with a stray cpu_req pulse during the miss.
        do_req(1'b1, 32'h0000_1850, 32'hCAFE_F00D, 4'hF, 0, 0, 1'b0, rd);
        do_req(1'b0, 32'h0000_1048, 32'h0, 4'h0, 10, 10, 1'b1, rd);
        check("t5_rdata", rd, 32'hDEAD3344);
        check("t5_wb_addr", seen_wb_addr, 32'h0000_1840);

        // Reset while the refill read is outstanding.
        predict(1'b0, 32'h0000_2050, 32'h0, 4'h0, 0, 1000);
        wb_delay = 0; rf_delay = 1000;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2050;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("t6_in_alloc", {mem_req, mem_we}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("t6_mem_req_async", mem_req, 1'b0);
        check("t6_ready", cpu_ready, 1'b0);
        check("t6_enable", c_enable, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_no_ready", cpu_ready, 1'b0);
        end
        release_reset();
        do_req(1'b0, 32'h0000_1048, 32'h0, 4'h0, 0, 0, 1'b0, rd);
        check("t6_reload", rd, 32'hDEAD3344);

        // Randomised traffic over a few conflicting sets.
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'b00};
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd);
        end

`ifdef DCACHE_STATS_EN
        check("stat_hits", stat_hits, 32'(m_hits));
        check("stat_misses", stat_misses, 32'(m_misses));
        check("stat_wbs", stat_wbs, 32'(m_wbs));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Miss-handling controller that sits directly upstream of the 64-line, direct-mapped, 256-bit-line dcache data/tag array.
- Accepts single-word CPU loads and stores, drives the array's enable, compare, read and reset strobes, and runs dirty-victim writeback and line refill over a line-wide memory handshake.
- Controller registers update on posedge clk. The array updates on negedge, so array results are stable at the next posedge.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits.
- INDEX_W, 6, set index width (address bits 10:5).
- OFFSET_W, 5, byte offset within line; word select is bits 4:2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  word-aligned byte address.
- cpu_wdata  in  32  store data.
- cpu_be  in  4  store byte enables.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  load data, valid while cpu_ready is high.
- c_enable, c_rst, c_compare, c_read  out  1 each  array strobes.
- c_address  out  32  array address.
- c_data_in  out  32  array word write data.
- c_byte_w_en  out  4  array byte enables.
- c_data_line_in  out  256  refill line to array.
- c_hit, c_valid, c_dirty  in  1 each  array status; c_hit is a tag match only.
- c_data_out  in  32  array word read data.
- c_data_line_out  in  256  array line read data.
- c_address_out  in  32  victim line address.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = line write, 0 = line read.
- mem_addr  out  32  line-aligned memory address.
- mem_wdata  out  256  writeback line.
- mem_ack  in  1  memory acknowledge.
- mem_rdata  in  256  refill line, valid in the ack cycle.

Behaviour:
- Reset:
  - rst_n low forces state INIT and clears all outputs and latches to 0.
  - A memory transaction in flight is abandoned: mem_req drops immediately.
- States: INIT, IDLE, COMPARE, WRITE, WRITEBACK, ALLOCATE, FILL, DONE.
- INIT:
  - Drives c_enable=1 and c_rst=1 for exactly one cycle, invalidating all lines.
  - Then goes to IDLE.
- IDLE:
  - If cpu_req=1, latch addr, we, wdata and be, then go to COMPARE.
  - cpu_req in any other state is ignored.
- COMPARE:
  - Drives c_enable=1, c_compare=1, c_read=1, c_address = latched addr.
  - Real hit is defined as c_hit & c_valid.
  - Load hit: capture c_data_out into cpu_rdata, go to DONE.
  - Store hit: go to WRITE.
  - Miss: capture c_address_out and c_data_line_out into the victim buffer. If c_valid & c_dirty, go to WRITEBACK, else go to ALLOCATE.
- WRITE:
  - Drives c_enable=1, c_compare=1, c_read=0, c_data_in=wdata, c_byte_w_en=be.
  - Then goes to DONE.
- WRITEBACK:
  - Drives mem_req=1, mem_we=1, mem_addr = victim address, mem_wdata = victim line.
  - All held stable until mem_ack=1, then go to ALLOCATE.
- ALLOCATE:
  - Drives mem_req=1, mem_we=0, mem_addr = {addr[31:5], 5'b0}.
  - On mem_ack, capture mem_rdata into the refill buffer, go to FILL.
- FILL:
  - Drives c_enable=1, c_compare=0, c_read=0, c_data_line_in = refill buffer.
  - The array installs the line clean and valid. Then return to COMPARE; the retry must hit.
- DONE:
  - cpu_ready=1 for one cycle, cpu_rdata held; then go to IDLE.
- Latency, counted from the accept cycle:
  - load hit: cpu_ready at cycle +2.
  - store hit: cpu_ready at cycle +3.
  - clean miss: +2 + ack wait + 2 extra cycles beyond a hit.
  - dirty miss: adds the writeback wait on top of a clean miss.
- Memory handshake:
  - mem_req rises on state entry and falls the cycle after mem_ack.
  - mem_ack with mem_req=0 is ignored.
  - There is no timeout.
- Defaults: array strobes are 0 in every state not listed above.

Optional Feature:
- DCACHE_STATS_EN defined:
  - Adds outputs stat_hits, stat_misses and stat_wbs, 32 bits each.
  - Counters are incremented on first-pass COMPARE hit, first-pass COMPARE miss, and WRITEBACK ack respectively.
  - Retry compares are not counted.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- dcache_pkg holds:
  - the state enum;
  - ADDR_W, LINE_W, INDEX_W and OFFSET_W;
  - tag, index and word-select slice constants.
- Sub-module dcache_stats holds the three saturating counters and is instantiated only under DCACHE_STATS_EN.

Test Plan:
1. Reset release -> c_rst high for exactly one cycle; then a load to 0x00001048 misses with no writeback. mem read at 0x00001040; ack line word2 = 0xDEADBEEF -> cpu_rdata = 0xDEADBEEF.
2. Load 0x00001048 again -> cpu_ready two cycles after accept, mem_req stays 0.
3. Store 0x00001048 with data 0x11223344, be = 4'b0011 -> cpu_ready at +3. A following load returns 0xDEAD3344.
4. Load 0x00001848 (same index 2, different tag) -> writeback with mem_we=1, mem_addr 0x00001040, mem_wdata word2 = 0xDEAD3344. Then refill read at 0x00001840.
5. mem_ack delayed 10 cycles -> mem_req, mem_addr and mem_wdata stable throughout, cpu_ready stays 0. cpu_req pulses meanwhile are ignored.
6. rst_n low mid-ALLOCATE -> mem_req = 0 asynchronously, state INIT, no cpu_ready issued.
